axi_slave_mem: RTL and testbench

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

---
 rtl/axi_slave_mem.sv | 253 +++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
// Single-beat AXI4 slave memory: independent write and read FSMs, byte-strobed
// writes, one-cycle registered reads, SLVERR for bursts/wrong size/out of range.
module axi_slave_mem #(
    parameter int                    data_len  = 128,
    parameter int                    mem_depth = 1024,
    parameter logic [data_len-1:0]   data_init = 128'd0
) (
    input  logic                ACLK,
    input  logic                ARESET,
    // AW channel
    input  logic                S_AXI_AWID,
    input  logic [26:0]         S_AXI_AWADDR,
    input  logic [7:0]          S_AXI_AWLEN,
    input  logic [2:0]          S_AXI_AWSIZE,
    input  logic [1:0]          S_AXI_AWBURST,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,
    // W channel
    input  logic [data_len-1:0] S_AXI_WDATA,
    input  logic [15:0]         S_AXI_WSTRB,
    input  logic                S_AXI_WLAST,
    input  logic                S_AXI_WVALID,
    output logic                S_AXI_WREADY,
    // B channel
    output logic                S_AXI_BID,
    output logic [1:0]          S_AXI_BRESP,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,
    // AR channel
    input  logic                S_AXI_ARID,
    input  logic [26:0]         S_AXI_ARADDR,
    input  logic [7:0]          S_AXI_ARLEN,
    input  logic [2:0]          S_AXI_ARSIZE,
    input  logic [1:0]          S_AXI_ARBURST,
    input  logic                S_AXI_ARVALID,
    output logic                S_AXI_ARREADY,
    // R channel
    output logic                S_AXI_RID,
    output logic [data_len-1:0] S_AXI_RDATA,
    output logic [1:0]          S_AXI_RRESP,
    output logic                S_AXI_RLAST,
    output logic                S_AXI_RVALID,
    input  logic                S_AXI_RREADY
);

    localparam int idx_w = $clog2(mem_depth);
    localparam int lanes = data_len / 8;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t              w_state_reg, w_state_next;
    logic                  aw_full_reg, aw_full_next;
    logic                  w_full_reg, w_full_next;
    logic                  awready_reg, awready_next;
    logic                  wready_reg, wready_next;
    logic                  bvalid_reg, bvalid_next;
    logic [1:0]            bresp_reg, bresp_next;
    logic                  bid_reg, bid_next;
    logic [26:0]           aw_addr_reg;
    logic                  aw_id_reg;
    logic [7:0]            aw_len_reg;
    logic [2:0]            aw_size_reg;
    logic [data_len-1:0]   w_data_reg;
    logic [15:0]           w_strb_reg;

    r_state_t              r_state_reg, r_state_next;
    logic                  arready_reg, arready_next;
    logic                  rvalid_reg, rvalid_next;
    logic                  rlast_reg, rlast_next;
    logic [1:0]            rresp_reg, rresp_next;
    logic                  rid_reg, rid_next;
    logic [data_len-1:0]   rdata_bus;

    // READY flops are only ever 1 in the idle states, so these are the handshakes.
    logic aw_hs, w_hs, ar_hs, commit, wr_err, rd_err;
    logic [idx_w-1:0] wr_idx, rd_idx;

    assign aw_hs  = S_AXI_AWVALID & awready_reg;
    assign w_hs   = S_AXI_WVALID & wready_reg;
    assign ar_hs  = S_AXI_ARVALID & arready_reg;
    assign commit = (w_state_reg == W_IDLE) & aw_full_reg & w_full_reg;

    assign wr_idx = aw_addr_reg[idx_w+3:4];
    assign rd_idx = S_AXI_ARADDR[idx_w+3:4];
    assign wr_err = (aw_addr_reg[26:idx_w+4] != '0) || (aw_len_reg != 8'd0) ||
                    (aw_size_reg != 3'b100);
    assign rd_err = (S_AXI_ARADDR[26:idx_w+4] != '0) || (S_AXI_ARLEN != 8'd0) ||
                    (S_AXI_ARSIZE != 3'b100);

    // Byte offset, burst type and WLAST carry no information for single-beat access.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, aw_addr_reg[3:0], S_AXI_ARADDR[3:0],
                             S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_WLAST};

    // Write FSM next-state: fill holding registers in any order, commit when both are full.
    always_comb begin
        w_state_next = w_state_reg;
        aw_full_next = aw_full_reg;
        w_full_next  = w_full_reg;
        bvalid_next  = bvalid_reg;
        bresp_next   = bresp_reg;
        bid_next     = bid_reg;
        case (w_state_reg)
            W_IDLE: begin
                if (aw_hs) aw_full_next = 1'b1;
                if (w_hs)  w_full_next  = 1'b1;
                if (commit) begin
                    aw_full_next = 1'b0;
                    w_full_next  = 1'b0;
                    bvalid_next  = 1'b1;
                    bresp_next   = wr_err ? 2'b10 : 2'b00;
                    bid_next     = aw_id_reg;
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_next  = 1'b0;
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
        awready_next = (w_state_next == W_IDLE) & ~aw_full_next;
        wready_next  = (w_state_next == W_IDLE) & ~w_full_next;
    end

    // Write FSM state, registered READY/B outputs and holding registers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_reg <= W_IDLE;
            aw_full_reg <= 1'b0;
            w_full_reg  <= 1'b0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= 2'b00;
            bid_reg     <= 1'b0;
            aw_addr_reg <= '0;
            aw_id_reg   <= 1'b0;
            aw_len_reg  <= '0;
            aw_size_reg <= '0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
        end else begin
            w_state_reg <= w_state_next;
            aw_full_reg <= aw_full_next;
            w_full_reg  <= w_full_next;
            awready_reg <= awready_next;
            wready_reg  <= wready_next;
            bvalid_reg  <= bvalid_next;
            bresp_reg   <= bresp_next;
            bid_reg     <= bid_next;
            if (aw_hs) begin
                aw_addr_reg <= S_AXI_AWADDR;
                aw_id_reg   <= S_AXI_AWID;
                aw_len_reg  <= S_AXI_AWLEN;
                aw_size_reg <= S_AXI_AWSIZE;
            end
            if (w_hs) begin
                w_data_reg <= S_AXI_WDATA;
                w_strb_reg <= S_AXI_WSTRB;
            end
        end
    end

    // Read FSM next-state: accept in R_IDLE, hold the beat until RREADY.
    always_comb begin
        r_state_next = r_state_reg;
        rvalid_next  = rvalid_reg;
        rlast_next   = rlast_reg;
        rresp_next   = rresp_reg;
        rid_next     = rid_reg;
        case (r_state_reg)
            R_IDLE: begin
                if (ar_hs) begin
                    rvalid_next  = 1'b1;
                    rlast_next   = 1'b1;
                    rresp_next   = rd_err ? 2'b10 : 2'b00;
                    rid_next     = S_AXI_ARID;
                    r_state_next = R_DATA;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rvalid_next  = 1'b0;
                    rlast_next   = 1'b0;
                    r_state_next = R_IDLE;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
        arready_next = (r_state_next == R_IDLE);
    end

    // Read FSM state and registered R-channel control outputs.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state_reg <= R_IDLE;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rlast_reg   <= 1'b0;
            rresp_reg   <= 2'b00;
            rid_reg     <= 1'b0;
        end else begin
            r_state_reg <= r_state_next;
            arready_reg <= arready_next;
            rvalid_reg  <= rvalid_next;
            rlast_reg   <= rlast_next;
            rresp_reg   <= rresp_next;
            rid_reg     <= rid_next;
        end
    end

    // One narrow RAM per byte lane so each strobe bit is a plain write enable.
    genvar gi;
    generate
        for (gi = 0; gi < lanes; gi++) begin : g_lane
            logic [7:0] mem_lane [mem_depth];
            logic [7:0] rd_lane_reg;

            // Byte write on commit; errored writes never reach the array.
            always_ff @(posedge ACLK) begin
                if (commit && !wr_err && w_strb_reg[gi])
                    mem_lane[wr_idx] <= w_data_reg[gi*8 +: 8];
            end

            // Registered read; sampling in the commit edge yields the pre-write data.
            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET)
                    rd_lane_reg <= data_init[gi*8 +: 8];
                else if (ar_hs)
                    rd_lane_reg <= rd_err ? data_init[gi*8 +: 8] : mem_lane[rd_idx];
            end

            assign rdata_bus[gi*8 +: 8] = rd_lane_reg;
        end
    endgenerate

    assign S_AXI_AWREADY = awready_reg;
    assign S_AXI_WREADY  = wready_reg;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_BRESP   = bresp_reg;
    assign S_AXI_BID     = bid_reg;
    assign S_AXI_ARREADY = arready_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RLAST   = rlast_reg;
    assign S_AXI_RRESP   = rresp_reg;
    assign S_AXI_RID     = rid_reg;
    assign S_AXI_RDATA   = rdata_bus;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: handshakes, strobes, errors, stalls,
// read-before-write and asynchronous reset abort.
module tb_axi_slave_mem;

    localparam logic [127:0] DINIT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic         S_AXI_AWID;
    logic [26:0]  S_AXI_AWADDR;
    logic [7:0]   S_AXI_AWLEN;
    logic [2:0]   S_AXI_AWSIZE;
    logic [1:0]   S_AXI_AWBURST;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [127:0] S_AXI_WDATA;
    logic [15:0]  S_AXI_WSTRB;
    logic         S_AXI_WLAST;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic         S_AXI_BID;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic         S_AXI_ARID;
    logic [26:0]  S_AXI_ARADDR;
    logic [7:0]   S_AXI_ARLEN;
    logic [2:0]   S_AXI_ARSIZE;
    logic [1:0]   S_AXI_ARBURST;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic         S_AXI_RID;
    logic [127:0] S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RLAST;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;

    int n_tests = 0;
    int n_fail  = 0;

    axi_slave_mem #(.data_len(128), .mem_depth(1024), .data_init(DINIT)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    // Absolute time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic aw_send(input logic [26:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic id);
        bit ok = 1'b0;
        S_AXI_AWADDR = a; S_AXI_AWLEN = len; S_AXI_AWSIZE = size; S_AXI_AWID = id;
        S_AXI_AWVALID = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge ACLK);
            ok = S_AXI_AWREADY;
            tick();
        end
        S_AXI_AWVALID = 1'b0;
        chk("aw_accept", ok, 1);
    endtask

    task automatic w_send(input logic [127:0] d, input logic [15:0] strb);
        bit ok = 1'b0;
        S_AXI_WDATA = d; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge ACLK);
            ok = S_AXI_WREADY;
            tick();
        end
        S_AXI_WVALID = 1'b0;
        chk("w_accept", ok, 1);
    endtask

    task automatic ar_send(input logic [26:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic id);
        bit ok = 1'b0;
        S_AXI_ARADDR = a; S_AXI_ARLEN = len; S_AXI_ARSIZE = size; S_AXI_ARID = id;
        S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge ACLK);
            ok = S_AXI_ARREADY;
            tick();
        end
        S_AXI_ARVALID = 1'b0;
        chk("ar_accept", ok, 1);
    endtask

    task automatic b_expect(input string tag, input logic [1:0] resp, input logic id);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge ACLK);
            seen = S_AXI_BVALID;
        end
        chk({tag, "_bvalid"}, seen, 1);
        chk({tag, "_bresp"}, S_AXI_BRESP, resp);
        chk({tag, "_bid"}, S_AXI_BID, id);
        tick();
        if (S_AXI_BREADY) chk({tag, "_bclear"}, S_AXI_BVALID, 0);
    endtask

    // Called right after ar_send: the beat must already be valid (1-cycle latency).
    task automatic r_expect(input string tag, input logic [127:0] d,
                            input logic [1:0] resp, input logic id);
        chk({tag, "_rvalid"}, S_AXI_RVALID, 1);
        chk({tag, "_rdata"}, S_AXI_RDATA, d);
        chk({tag, "_rresp"}, S_AXI_RRESP, resp);
        chk({tag, "_rlast"}, S_AXI_RLAST, 1);
        chk({tag, "_rid"}, S_AXI_RID, id);
        if (S_AXI_RREADY) begin
            tick();
            chk({tag, "_rclear"}, S_AXI_RVALID, 0);
            chk({tag, "_rlastclr"}, S_AXI_RLAST, 0);
            chk({tag, "_rhold"}, S_AXI_RDATA, d);
        end
    endtask

    task automatic write_word(input string tag, input logic [26:0] a, input logic [127:0] d,
                              input logic [15:0] strb, input logic id, input logic [1:0] resp);
        aw_send(a, 8'd0, 3'b100, id);
        w_send(d, strb);
        b_expect(tag, resp, id);
    endtask

    task automatic read_word(input string tag, input logic [26:0] a, input logic [127:0] d,
                             input logic [1:0] resp, input logic id);
        ar_send(a, 8'd0, 3'b100, id);
        r_expect(tag, d, resp, id);
    endtask

    initial begin
        logic [127:0] d1, d2, d3, d5a, d5b, d7, dz, dlast;
        d1 = {16{8'h11}}; d2 = {16{8'h22}}; d3 = {16{8'h33}};
        d5a = {16{8'h55}}; d5b = {16{8'hAA}}; d7 = {16{8'h77}};
        dz = '0; dlast = 128'hC0FF_EE00_1234_5678_9ABC_DEF0_0BAD_F00D;

        ARESET = 1'b1;
        S_AXI_AWID = 0; S_AXI_AWADDR = 0; S_AXI_AWLEN = 0; S_AXI_AWSIZE = 3'b100;
        S_AXI_AWBURST = 2'b01; S_AXI_AWVALID = 0;
        S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WLAST = 1; S_AXI_WVALID = 0;
        S_AXI_BREADY = 1;
        S_AXI_ARID = 0; S_AXI_ARADDR = 0; S_AXI_ARLEN = 0; S_AXI_ARSIZE = 3'b100;
        S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 0; S_AXI_RREADY = 1;

        // Reset state, including across clock edges while held.
        #1;
        chk("rst_awready", S_AXI_AWREADY, 0);
        chk("rst_wready", S_AXI_WREADY, 0);
        chk("rst_arready", S_AXI_ARREADY, 0);
        chk("rst_bvalid", S_AXI_BVALID, 0);
        chk("rst_bresp", S_AXI_BRESP, 0);
        chk("rst_bid", S_AXI_BID, 0);
        chk("rst_rvalid", S_AXI_RVALID, 0);
        chk("rst_rlast", S_AXI_RLAST, 0);
        chk("rst_rresp", S_AXI_RRESP, 0);
        chk("rst_rid", S_AXI_RID, 0);
        chk("rst_rdata", S_AXI_RDATA, DINIT);
        tick(); tick();
        chk("rst_held_arready", S_AXI_ARREADY, 0);
        #3 ARESET = 1'b0;
        #1;
        chk("post_rst_awready_low", S_AXI_AWREADY, 0);
        chk("post_rst_arready_low", S_AXI_ARREADY, 0);
        tick();
        chk("post_rst_awready", S_AXI_AWREADY, 1);
        chk("post_rst_wready", S_AXI_WREADY, 1);
        chk("post_rst_arready", S_AXI_ARREADY, 1);

        // AW first, W two cycles later, then read back.
        aw_send(27'h000_0010, 8'd0, 3'b100, 1'b1);
        chk("awfirst_awready", S_AXI_AWREADY, 0);
        chk("awfirst_wready", S_AXI_WREADY, 1);
        tick(); tick();
        chk("awfirst_nob", S_AXI_BVALID, 0);
        w_send(d1, 16'hFFFF);
        b_expect("awfirst", 2'b00, 1'b1);
        read_word("rd_word1", 27'h000_0010, d1, 2'b00, 1'b1);

        // W before AW, partial strobe onto a zeroed word.
        write_word("zero_w2", 27'h000_0020, dz, 16'hFFFF, 1'b0, 2'b00);
        w_send({16{8'hFF}}, 16'h000F);
        chk("wfirst_wready", S_AXI_WREADY, 0);
        chk("wfirst_awready", S_AXI_AWREADY, 1);
        aw_send(27'h000_0020, 8'd0, 3'b100, 1'b0);
        b_expect("wfirst", 2'b00, 1'b0);
        read_word("rd_strb", 27'h000_002C, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF,
                  2'b00, 1'b0);

        // Error cases: out-of-range read, burst/size writes leave memory untouched.
        read_word("rd_oor", 27'h400_0000, DINIT, 2'b10, 1'b1);
        aw_send(27'h000_0010, 8'd3, 3'b100, 1'b0);
        w_send(d2, 16'hFFFF);
        b_expect("wr_len3", 2'b10, 1'b0);
        aw_send(27'h000_0010, 8'd0, 3'b011, 1'b1);
        w_send(d2, 16'hFFFF);
        b_expect("wr_size", 2'b10, 1'b1);
        read_word("rd_after_err", 27'h000_0010, d1, 2'b00, 1'b0);
        ar_send(27'h000_0010, 8'd1, 3'b100, 1'b1);
        r_expect("rd_len1", DINIT, 2'b10, 1'b1);

        // Top-of-memory boundary: last word valid, first word beyond it is an error.
        write_word("last_word", 27'h000_3FF0, dlast, 16'hFFFF, 1'b1, 2'b00);
        read_word("rd_last", 27'h000_3FF0, dlast, 2'b00, 1'b1);
        write_word("w0_init", 27'h000_0000, d3, 16'hFFFF, 1'b0, 2'b00);
        write_word("wr_oor", 27'h000_4000, d2, 16'hFFFF, 1'b0, 2'b10);
        read_word("rd_oor_bound", 27'h000_4000, DINIT, 2'b10, 1'b0);
        read_word("rd_w0_intact", 27'h000_0000, d3, 2'b00, 1'b0);

        // B channel stall.
        S_AXI_BREADY = 1'b0;
        aw_send(27'h000_0030, 8'd0, 3'b100, 1'b1);
        w_send(d3, 16'hFFFF);
        b_expect("bstall", 2'b00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            chk("bstall_bvalid", S_AXI_BVALID, 1);
            chk("bstall_bresp", S_AXI_BRESP, 2'b00);
            chk("bstall_bid", S_AXI_BID, 1);
            chk("bstall_awready", S_AXI_AWREADY, 0);
        end
        S_AXI_BREADY = 1'b1;
        tick();
        chk("bstall_release", S_AXI_BVALID, 0);

        // R channel stall.
        S_AXI_RREADY = 1'b0;
        ar_send(27'h000_0030, 8'd0, 3'b100, 1'b1);
        r_expect("rstall", d3, 2'b00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rstall_rvalid", S_AXI_RVALID, 1);
            chk("rstall_rdata", S_AXI_RDATA, d3);
            chk("rstall_rlast", S_AXI_RLAST, 1);
            chk("rstall_arready", S_AXI_ARREADY, 0);
        end
        S_AXI_RREADY = 1'b1;
        tick();
        chk("rstall_release", S_AXI_RVALID, 0);

        // Same-edge commit and AR to one word: read sees the old data.
        write_word("w5_old", 27'h000_0050, d5a, 16'hFFFF, 1'b0, 2'b00);
        S_AXI_AWADDR = 27'h000_0050; S_AXI_AWLEN = 0; S_AXI_AWSIZE = 3'b100; S_AXI_AWID = 1;
        S_AXI_WDATA = d5b; S_AXI_WSTRB = 16'hFFFF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        chk("rbw_awready", S_AXI_AWREADY, 1);
        chk("rbw_wready", S_AXI_WREADY, 1);
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_ARADDR = 27'h000_0050; S_AXI_ARLEN = 0; S_AXI_ARSIZE = 3'b100; S_AXI_ARID = 0;
        S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        chk("rbw_arready", S_AXI_ARREADY, 1);
        tick();
        S_AXI_ARVALID = 1'b0;
        chk("rbw_bvalid", S_AXI_BVALID, 1);
        r_expect("rbw_old", d5a, 2'b00, 1'b0);
        read_word("rbw_new", 27'h000_0050, d5b, 2'b00, 1'b1);

        // Asynchronous reset between AW and W aborts the write.
        write_word("w7_init", 27'h000_0070, d7, 16'hFFFF, 1'b0, 2'b00);
        S_AXI_RREADY = 1'b0;
        ar_send(27'h000_0070, 8'd0, 3'b100, 1'b1);
        chk("pre_rst_rvalid", S_AXI_RVALID, 1);
        aw_send(27'h000_0070, 8'd0, 3'b100, 1'b1);
        S_AXI_WDATA = {16{8'h88}};
        #2 ARESET = 1'b1;
        #1;
        chk("arst_rvalid", S_AXI_RVALID, 0);
        chk("arst_bvalid", S_AXI_BVALID, 0);
        chk("arst_rlast", S_AXI_RLAST, 0);
        chk("arst_awready", S_AXI_AWREADY, 0);
        chk("arst_wready", S_AXI_WREADY, 0);
        chk("arst_rdata", S_AXI_RDATA, DINIT);
        tick();
        #2 ARESET = 1'b0;
        S_AXI_RREADY = 1'b1;
        #1;
        chk("arst_rel_arready_low", S_AXI_ARREADY, 0);
        tick();
        chk("arst_rel_awready", S_AXI_AWREADY, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("arst_no_b", S_AXI_BVALID, 0);
        end
        read_word("arst_w7_intact", 27'h000_0070, d7, 2'b00, 1'b0);

        // A lone W beat with no address must not commit or respond.
        w_send({16{8'h99}}, 16'hFFFF);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lone_w_no_b", S_AXI_BVALID, 0);
        end
        read_word("lone_w_w7", 27'h000_0070, d7, 2'b00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
